// File: rtl/apu_package.sv
// Shared APU constants, plus the request payload type reused by the shared-FPU interconnect.
package apu_package;

    localparam int unsigned C_APUTYPES    = 4;
    localparam int unsigned WAPUTYPE      = 2;

    localparam int unsigned NARGS_CPU     = 3;
    localparam int unsigned WOP_CPU       = 6;
    localparam int unsigned NDSFLAGS_CPU  = 15;
    localparam int unsigned NUSFLAGS_CPU  = 5;

    localparam int unsigned APU_FLAGS_INT = 0;
    localparam int unsigned APU_FLAGS_DSP = 1;
    localparam int unsigned APU_FLAGS_FP  = 2;

    localparam int unsigned NB_CORES_CPU  = 4;
    localparam int unsigned WCORE         = $clog2(NB_CORES_CPU);

    typedef struct packed {
        logic [WOP_CPU-1:0]             op;
        logic [NARGS_CPU-1:0][31:0]     operands;
        logic [NDSFLAGS_CPU-1:0]        flags;
    } apu_req_t;

    // Core index width that stays at least one bit wide for degenerate core counts.
    function automatic int unsigned core_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apu_tag_fifo.sv
// In-order tag FIFO holding the issuing core index of every operation outstanding in the unit.
module apu_tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o,
    output logic [CntW-1:0]  count_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]             count_q, count_d;
    logic                        do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/apu_shared_arbiter.sv
// Round-robin arbiter sharing one APU unit between cores; tags outstanding ops and routes
// each result back to its issuing core.
module apu_shared_arbiter
    import apu_package::*;
#(
    parameter int unsigned NB_CORES        = 4,
    parameter int unsigned APU_TYPE        = 0,
    parameter int unsigned NARGS           = NARGS_CPU,
    parameter int unsigned WOP             = WOP_CPU,
    parameter int unsigned NDSFLAGS        = NDSFLAGS_CPU,
    parameter int unsigned NUSFLAGS        = NUSFLAGS_CPU,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NB_CORES-1:0]                  core_req_i,
    input  logic [NB_CORES-1:0][WAPUTYPE-1:0]    core_type_i,
    input  logic [NB_CORES-1:0][WOP-1:0]         core_op_i,
    input  logic [NB_CORES-1:0][NARGS-1:0][31:0] core_operands_i,
    input  logic [NB_CORES-1:0][NDSFLAGS-1:0]    core_flags_i,
    output logic [NB_CORES-1:0]                  core_gnt_o,
    output logic [NB_CORES-1:0]                  core_rvalid_o,
    output logic [31:0]                          core_rdata_o,
    output logic [NUSFLAGS-1:0]                  core_rflags_o,
    output logic                                 unit_req_o,
    input  logic                                 unit_gnt_i,
    output logic [WOP-1:0]                       unit_op_o,
    output logic [NARGS-1:0][31:0]               unit_operands_o,
    output logic [NDSFLAGS-1:0]                  unit_flags_o,
    input  logic                                 unit_rvalid_i,
    input  logic [31:0]                          unit_rdata_i,
    input  logic [NUSFLAGS-1:0]                  unit_rflags_i,
    output logic                                 err_o
);
    localparam int unsigned CoreW = core_idx_width(NB_CORES);
    localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING + 1);

    logic [NB_CORES-1:0] elig;
    logic                any_elig, found;
    logic [CoreW-1:0]    winner;
    logic [CoreW-1:0]    rr_ptr_q, rr_ptr_d;
    logic                err_q, err_d;
    logic                transfer, pop, slot_free;
    logic                tag_full, tag_empty;
    logic [CoreW-1:0]    tag_head;
    logic [CntW-1:0]     tag_count;

    // First eligible core at or after rr_ptr, wrapping around the core count.
    always_comb begin
        int unsigned idx;
        found  = 1'b0;
        winner = '0;
        for (int unsigned c = 0; c < NB_CORES; c++) begin
            elig[c] = core_req_i[c] && (core_type_i[c] == WAPUTYPE'(APU_TYPE));
        end
        for (int unsigned i = 0; i < NB_CORES; i++) begin
            idx = (32'(rr_ptr_q) + i) % NB_CORES;
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = CoreW'(idx);
            end
        end
        any_elig = |elig;
    end

    // Full FIFO blocks the push even if a result pops this cycle: no rvalid-to-gnt path.
    assign slot_free  = !tag_full && (tag_count < CntW'(MAX_OUTSTANDING));
    assign unit_req_o = any_elig && slot_free && !rst_i;
    assign transfer   = unit_req_o && unit_gnt_i;
    assign pop        = unit_rvalid_i && !tag_empty && !rst_i;

    always_comb begin
        core_gnt_o      = '0;
        core_rvalid_o   = '0;
        unit_op_o       = '0;
        unit_operands_o = '0;
        unit_flags_o    = '0;
        if (any_elig) begin
            unit_op_o       = core_op_i[winner];
            unit_operands_o = core_operands_i[winner];
            unit_flags_o    = core_flags_i[winner];
        end
        if (transfer) begin
            core_gnt_o[winner] = 1'b1;
        end
        if (pop) begin
            core_rvalid_o[tag_head] = 1'b1;
        end
        rr_ptr_d = rr_ptr_q;
        if (transfer) begin
            rr_ptr_d = (winner == CoreW'(NB_CORES - 1)) ? '0 : winner + 1'b1;
        end
        err_d = err_q || (unit_rvalid_i && tag_empty);
    end

    assign core_rdata_o  = unit_rdata_i;
    assign core_rflags_o = unit_rflags_i;
    assign err_o         = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    apu_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (CoreW)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (transfer),
        .data_i  (winner),
        .pop_i   (pop),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .head_o  (tag_head),
        .count_o (tag_count)
    );

endmodule
